tl_byte_host: RTL and testbench
===============================

# tl_byte_host

Byte-stream-to-TileLink-UL host bridge: parses framed read/write commands arriving as bytes (e.g. from the UART receive path or a debug transport) and issues single-beat 32-bit TL-UL Get/PutFullData requests as an additional crossbar host. It drives the external host port of the system crossbar, giving off-chip tooling access to ROM/RAM and peripherals. It returns status and read data as a byte stream.

## Interface
- TimeoutCycles, 1_000_000: idle cycles allowed between bytes of one command before abort
- SourceId, 0: value driven on a_source
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- rx_data_i  in  8  incoming command byte
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  bridge accepts byte (transfer = valid & ready)
- tx_data_o  out  8  response byte
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  sink accepts response byte
- tl_o  out  tl_h2d_t  TL-UL host request channel A, d_ready
- tl_i  in  tl_d2h_t  TL-UL response channel D, a_ready
- busy_o  out  1  high in any state other than IDLE

## Operation
- Frame: opcode byte, 4 address bytes LSB first, then for writes 4 data bytes LSB first.
- Opcodes: 0x57 'W' write, 0x52 'R' read. Any other opcode is answered with 0x3F '?', and the bridge returns to IDLE.
- States: IDLE, ADDR, DATA, REQ, RESP, SEND.
  - IDLE takes the opcode: go to ADDR on a valid opcode, otherwise go to SEND with '?'.
  - ADDR takes 4 bytes; a 2-bit index wraps 3→0. After the 4th byte, a write goes to DATA and a read goes to REQ.
  - DATA takes 4 bytes, then goes to REQ.
  - Unaligned address (addr[1:0]≠0): skip TL. After the final frame byte, send 0x45 'E'.
- REQ drives a_valid=1 and holds it until a_ready:
  - a_opcode Get (4) or PutFullData (0), a_param 0, a_size 2, a_mask 4'hF, a_source SourceId, a_user default.
  - a_address and a_data are held stable while a_valid is high.
  - On a_ready, go to RESP.
- RESP captures the first d_valid beat.
  - d_error=1: response 'E' only.
  - Write with no error: response 0x4B 'K'.
  - Read with no error: 'K' followed by 4 data bytes LSB first.
- SEND shifts the response out, one byte per tx handshake, then returns to IDLE.
- One outstanding TL transaction maximum.
- d_ready=1 in all states. A D beat outside RESP (stray response after a reset) is discarded.
- Timeout: a counter runs only in ADDR/DATA and clears on each accepted byte. When it reaches TimeoutCycles−1, go to IDLE silently with no response byte. No timeout applies in REQ/RESP/SEND.

## Timing
- Reset values: rx_ready_o=1 (IDLE), tx_valid_o=0, a_valid=0, d_ready=1, busy_o=0, all data/address registers 0.
- rx_ready_o is 1 in IDLE/ADDR/DATA and 0 elsewhere; it is decoded combinationally from state.
- a_valid rises the cycle after the final frame byte is accepted.
- RESP is entered the cycle after the a_valid&a_ready transfer. A d_valid in that same transfer cycle cannot occur, since the xbar responds in ≥1 cycle.
- The first tx_valid comes the cycle after the D beat is captured.
- tx_data_o is stable while tx_valid_o=1 and tx_ready_i=0.
- Minimum latency, write frame to 'K', with a_ready and d_valid each arriving immediately: 3 cycles after the last byte.
- Reset asserted mid-operation forces IDLE asynchronously: a_valid drops and any partial response is lost. A later D beat is drained via d_ready=1.

## Structure
- Shared package tl_byte_host_pkg:
  - opcode/status byte constants ('W', 'R', 'K', 'E', '?');
  - state enum;
  - TL size/mask constants, with opcodes reused from tlul_pkg.
- One natural sub-module: tl_byte_host_tx. It is a 5-byte response serializer with a length input (1 or 5) and a valid/ready output.
- Top integration: instantiate with tl_o→tl_ext_h2d and tl_i→tl_ext_d2h.

## Test plan
- Write: bytes 57 00 00 00 80 EF BE AD DE → one PutFullData to 0x80000000 with data 0xDEADBEEF and mask F; on AccessAck, tx emits 4B.
- Read: bytes 52 00 00 00 80, with D returning 0x12345678 → tx emits 4B 78 56 34 12. Stall tx_ready_i 3 cycles mid-stream and check the data holds.
- Error: read with d_error=1 → tx emits 45 only. Address 0x80000002 → tx emits 45 and no a_valid is ever seen.
- Bad opcode 0x00 → tx emits 3F. The next valid frame is processed normally.
- Timeout (TimeoutCycles=16): send 52 00, then idle 16 cycles → busy_o falls with no tx and no a_valid. A fresh frame then succeeds.
- Backpressure/reset: hold a_ready=0 for 10 cycles and check the A fields stay stable. Assert rst_i while a_valid=1 → a_valid=0 immediately, and a late D beat is discarded.

Source files
------------

// File: rtl/tl_byte_host_pkg.sv
// -----------------------------------------------------------------------------
// tl_byte_host_pkg
// Shared definitions for the byte-stream to TL-UL host bridge: command and
// status byte codes, FSM state encoding, TL size/mask constants and the
// response-buffer geometry used by the serializer.
// -----------------------------------------------------------------------------
package tl_byte_host_pkg;

   // Command opcodes and response status bytes
   localparam logic [7:0] OP_WRITE   = 8'h57;  // 'W'
   localparam logic [7:0] OP_READ    = 8'h52;  // 'R'
   localparam logic [7:0] RSP_OK     = 8'h4B;  // 'K'
   localparam logic [7:0] RSP_ERR    = 8'h45;  // 'E'
   localparam logic [7:0] RSP_BADOP  = 8'h3F;  // '?'

   // Single-beat 32-bit accesses only
   localparam logic [1:0] TL_SIZE_WORD = 2'd2;
   localparam logic [3:0] TL_MASK_FULL = 4'hF;

   // Response buffer: status byte plus up to four read-data bytes
   localparam int unsigned RSP_BYTES     = 5;
   localparam logic [2:0]  RSP_LEN_SHORT = 3'd1;
   localparam logic [2:0]  RSP_LEN_LONG  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_REQ,
      ST_RESP,
      ST_SEND
   } state_e;

   // Status-only response packed into the serializer buffer (byte 0 first)
   function automatic logic [RSP_BYTES*8-1:0] short_rsp(input logic [7:0] status);
      return {{(RSP_BYTES*8-8){1'b0}}, status};
   endfunction

endpackage

// File: rtl/tlul_pkg.sv
// -----------------------------------------------------------------------------
// tlul_pkg
// Minimal TileLink-UL type package shared by crossbar hosts and devices.
// Provides the channel A / channel D opcode enums, the default a_user value
// and the packed host-to-device / device-to-host channel structs.
// -----------------------------------------------------------------------------
package tlul_pkg;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   typedef logic [13:0] tl_a_user_t;
   localparam tl_a_user_t TL_A_USER_DEFAULT = '0;

   typedef struct packed {
      logic        a_valid;
      tl_a_op_e    a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      tl_a_user_t  a_user;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      tl_d_op_e    d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic [13:0] d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/tl_byte_host_tx.sv
// -----------------------------------------------------------------------------
// tl_byte_host_tx
// Response serializer: loads up to five bytes and shifts them out LSB byte
// first over a valid/ready byte interface.
//   clk, rst      clock, asynchronous active-high reset
//   load          capture data/len (only asserted while the buffer is empty)
//   len           number of bytes to emit (1 or 5)
//   data          response bytes, byte 0 in data[7:0]
//   tx_data       current byte, stable until accepted
//   tx_valid      a byte is pending
//   tx_ready      sink accepts the pending byte
//   last          pending byte is the final one of the response
// -----------------------------------------------------------------------------
module tl_byte_host_tx
   import tl_byte_host_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [2:0]             len,
   input  logic [RSP_BYTES*8-1:0] data,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic                   last
);

   logic [RSP_BYTES*8-1:0] shift_reg;
   logic [2:0]             count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg <= '0;
         count_reg <= 3'd0;
      end else if (load) begin
         shift_reg <= data;
         count_reg <= len;
      end else if (tx_valid && tx_ready) begin
         shift_reg <= {8'h00, shift_reg[RSP_BYTES*8-1:8]};
         count_reg <= count_reg - 3'd1;
      end
   end

   assign tx_valid = (count_reg != 3'd0);
   assign tx_data  = shift_reg[7:0];
   assign last     = (count_reg == 3'd1);

endmodule

// File: rtl/tl_byte_host.sv
// -----------------------------------------------------------------------------
// tl_byte_host
// Byte-stream to TL-UL host bridge. Parses framed commands
//   'W' a0 a1 a2 a3 d0 d1 d2 d3   (write, little-endian address/data)
//   'R' a0 a1 a2 a3               (read)
// issues one single-beat 32-bit Get/PutFullData on the crossbar external
// host port (tl_o -> tl_ext_h2d, tl_i -> tl_ext_d2h) and answers with
// 'K' [+4 read bytes], 'E' (bus error or unaligned address) or '?'.
//   clk_i, rst_i          clock, asynchronous active-high reset
//   rx_data_i/valid/ready command byte stream in
//   tx_data_o/valid/ready response byte stream out
//   tl_o / tl_i           TL-UL host request / device response
//   busy_o                bridge is not idle
// Parameters: TimeoutCycles (inter-byte idle limit), SourceId (a_source).
// -----------------------------------------------------------------------------
module tl_byte_host
   import tlul_pkg::*;
   import tl_byte_host_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 1_000_000,
   parameter logic [7:0]  SourceId      = 8'd0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   output logic       rx_ready_o,
   output logic [7:0] tx_data_o,
   output logic       tx_valid_o,
   input  logic       tx_ready_i,
   output tl_h2d_t    tl_o,
   input  tl_d2h_t    tl_i,
   output logic       busy_o
);

   localparam int unsigned     TmoW    = $clog2(TimeoutCycles + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

   state_e      state_reg;
   logic [1:0]  idx_reg;
   logic        is_write_reg;
   logic [31:0] addr_reg;
   logic [31:0] data_reg;
   logic [TmoW-1:0] tmo_reg;
   logic        a_valid_reg;

   logic                   rx_fire;
   logic                   last_byte;
   logic                   misaligned;
   logic                   rsp_load;
   logic [2:0]             rsp_len;
   logic [RSP_BYTES*8-1:0] rsp_data;
   logic                   tx_last;

   assign rx_ready_o = (state_reg == ST_IDLE) || (state_reg == ST_ADDR) ||
                       (state_reg == ST_DATA);
   assign busy_o     = (state_reg != ST_IDLE);
   assign rx_fire    = rx_valid_i && rx_ready_o;
   assign last_byte  = (idx_reg == 2'd3);
   // addr[1:0] arrives with the first address byte, so it is final long
   // before the last frame byte is taken.
   assign misaligned = (addr_reg[1:0] != 2'b00);

   // Response selection; the serializer is loaded on the same edge the FSM
   // moves into SEND, so the first tx_valid follows on the next cycle.
   always_comb begin
      rsp_load = 1'b0;
      rsp_len  = RSP_LEN_SHORT;
      rsp_data = '0;
      unique case (state_reg)
         ST_IDLE: begin
            if (rx_fire && (rx_data_i != OP_WRITE) && (rx_data_i != OP_READ)) begin
               rsp_load = 1'b1;
               rsp_data = short_rsp(RSP_BADOP);
            end
         end
         ST_ADDR: begin
            if (rx_fire && last_byte && !is_write_reg && misaligned) begin
               rsp_load = 1'b1;
               rsp_data = short_rsp(RSP_ERR);
            end
         end
         ST_DATA: begin
            if (rx_fire && last_byte && misaligned) begin
               rsp_load = 1'b1;
               rsp_data = short_rsp(RSP_ERR);
            end
         end
         ST_RESP: begin
            if (tl_i.d_valid) begin
               rsp_load = 1'b1;
               if (tl_i.d_error) begin
                  rsp_data = short_rsp(RSP_ERR);
               end else if (is_write_reg) begin
                  rsp_data = short_rsp(RSP_OK);
               end else begin
                  rsp_len  = RSP_LEN_LONG;
                  rsp_data = {tl_i.d_data, RSP_OK};
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg    <= ST_IDLE;
         idx_reg      <= 2'd0;
         is_write_reg <= 1'b0;
         addr_reg     <= '0;
         data_reg     <= '0;
         tmo_reg      <= '0;
         a_valid_reg  <= 1'b0;
      end else begin
         unique case (state_reg)
            ST_IDLE: begin
               if (rx_fire) begin
                  if ((rx_data_i == OP_WRITE) || (rx_data_i == OP_READ)) begin
                     is_write_reg <= (rx_data_i == OP_WRITE);
                     idx_reg      <= 2'd0;
                     tmo_reg      <= '0;
                     state_reg    <= ST_ADDR;
                  end else begin
                     state_reg    <= ST_SEND;
                  end
               end
            end
            ST_ADDR: begin
               if (rx_fire) begin
                  addr_reg[{idx_reg, 3'b000} +: 8] <= rx_data_i;
                  idx_reg <= idx_reg + 2'd1;
                  tmo_reg <= '0;
                  if (last_byte) begin
                     if (is_write_reg) begin
                        state_reg <= ST_DATA;
                     end else if (misaligned) begin
                        state_reg <= ST_SEND;
                     end else begin
                        state_reg   <= ST_REQ;
                        a_valid_reg <= 1'b1;
                     end
                  end
               end else if (tmo_reg == TmoLast) begin
                  state_reg <= ST_IDLE;
               end else begin
                  tmo_reg <= tmo_reg + 1'b1;
               end
            end
            ST_DATA: begin
               if (rx_fire) begin
                  data_reg[{idx_reg, 3'b000} +: 8] <= rx_data_i;
                  idx_reg <= idx_reg + 2'd1;
                  tmo_reg <= '0;
                  if (last_byte) begin
                     if (misaligned) begin
                        state_reg <= ST_SEND;
                     end else begin
                        state_reg   <= ST_REQ;
                        a_valid_reg <= 1'b1;
                     end
                  end
               end else if (tmo_reg == TmoLast) begin
                  state_reg <= ST_IDLE;
               end else begin
                  tmo_reg <= tmo_reg + 1'b1;
               end
            end
            ST_REQ: begin
               if (tl_i.a_ready) begin
                  a_valid_reg <= 1'b0;
                  state_reg   <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (tl_i.d_valid) begin
                  state_reg <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (tx_last && tx_ready_i) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Request fields come straight from registers that do not change while
   // a_valid is high, so they hold through any a_ready backpressure.
   always_comb begin
      tl_o           = '0;
      tl_o.a_valid   = a_valid_reg;
      tl_o.a_opcode  = is_write_reg ? PutFullData : Get;
      tl_o.a_param   = 3'h0;
      tl_o.a_size    = TL_SIZE_WORD;
      tl_o.a_source  = SourceId;
      tl_o.a_address = addr_reg;
      tl_o.a_mask    = TL_MASK_FULL;
      tl_o.a_data    = data_reg;
      tl_o.a_user    = TL_A_USER_DEFAULT;
      tl_o.d_ready   = 1'b1;  // stray beats after a reset are simply drained
   end

   tl_byte_host_tx u_tx (
      .clk      (clk_i),
      .rst      (rst_i),
      .load     (rsp_load),
      .len      (rsp_len),
      .data     (rsp_data),
      .tx_data  (tx_data_o),
      .tx_valid (tx_valid_o),
      .tx_ready (tx_ready_i),
      .last     (tx_last)
   );

   logic unused_d_fields;
   assign unused_d_fields = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                              tl_i.d_source, tl_i.d_sink, tl_i.d_user};

endmodule

// File: tb/tb_tl_byte_host.sv
// -----------------------------------------------------------------------------
// tb_tl_byte_host
// Directed bench for tl_byte_host: write, read with A backpressure and tx
// stall, bus error, unaligned address, bad opcode, inter-byte timeout and
// asynchronous reset with a stray D beat. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_tl_byte_host;
   import tlul_pkg::*;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   tl_h2d_t    tl_o;
   tl_d2h_t    tl_i;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;
   int a_seen = 0;
   int tx_seen = 0;

   tl_byte_host #(
      .TimeoutCycles (16),
      .SourceId      (8'd0)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .rx_data_i  (rx_data),
      .rx_valid_i (rx_valid),
      .rx_ready_o (rx_ready),
      .tx_data_o  (tx_data),
      .tx_valid_o (tx_valid),
      .tx_ready_i (tx_ready),
      .tl_o       (tl_o),
      .tl_i       (tl_i),
      .busy_o     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tl_o.a_valid) a_seen <= a_seen + 1;
      if (tx_valid)     tx_seen <= tx_seen + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one byte and hold it until accepted; returns on the falling
   // edge after the accepting clock edge.
   task automatic send_byte(input logic [7:0] b);
      int w;
      rx_data  = b;
      rx_valid = 1'b1;
      w = 0;
      while (!rx_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("rx_accept", rx_ready, 1'b1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [31:0] addr,
                             input logic wr, input logic [31:0] data);
      send_byte(op);
      for (int i = 0; i < 4; i++) send_byte(addr[i*8 +: 8]);
      if (wr) for (int i = 0; i < 4; i++) send_byte(data[i*8 +: 8]);
   endtask

   // Device model for one transaction: checks the A beat for `stall` cycles
   // of backpressure, accepts it, then returns a D beat on the next cycle.
   task automatic serve_tl(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int stall,
                           input logic [31:0] rdata, input logic derr);
      int w;
      w = 0;
      while (!tl_o.a_valid && w < 50) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_a_valid"}, tl_o.a_valid, 1'b1);
      if (!tl_o.a_valid) return;
      for (int i = 0; i <= stall; i++) begin
         check({tag, "_a_valid_hold"}, tl_o.a_valid, 1'b1);
         check({tag, "_a_opcode"}, tl_o.a_opcode, wr ? 3'h0 : 3'h4);
         check({tag, "_a_address"}, tl_o.a_address, addr);
         check({tag, "_a_mask"}, tl_o.a_mask, 4'hF);
         check({tag, "_a_size"}, tl_o.a_size, 2'd2);
         check({tag, "_a_param"}, tl_o.a_param, 3'd0);
         check({tag, "_a_source"}, tl_o.a_source, 8'd0);
         if (wr) check({tag, "_a_data"}, tl_o.a_data, wdata);
         if (i < stall) @(negedge clk);
      end
      tl_i.a_ready = 1'b1;
      @(negedge clk);
      tl_i.a_ready  = 1'b0;
      check({tag, "_a_drop"}, tl_o.a_valid, 1'b0);
      tl_i.d_valid  = 1'b1;
      tl_i.d_opcode = wr ? AccessAck : AccessAckData;
      tl_i.d_data   = rdata;
      tl_i.d_error  = derr;
      @(negedge clk);
      tl_i.d_valid  = 1'b0;
      tl_i.d_error  = 1'b0;
      tl_i.d_data   = '0;
   endtask

   // Collect n response bytes (packed LSB first); optionally withhold
   // tx_ready for 3 cycles on byte stall_idx and check the byte holds.
   task automatic expect_tx(input string tag, input logic [39:0] exp, input int n,
                            input int stall_idx);
      int w;
      for (int i = 0; i < n; i++) begin
         w = 0;
         while (!tx_valid && w < 50) begin
            @(negedge clk);
            w++;
         end
         check({tag, "_tx_valid"}, tx_valid, 1'b1);
         check({tag, "_tx_byte"}, tx_data, exp[i*8 +: 8]);
         if (i == stall_idx) begin
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               check({tag, "_stall_valid"}, tx_valid, 1'b1);
               check({tag, "_stall_byte"}, tx_data, exp[i*8 +: 8]);
            end
         end
         tx_ready = 1'b1;
         @(negedge clk);
         tx_ready = 1'b0;
      end
      check({tag, "_tx_end"}, tx_valid, 1'b0);
      check({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      int a_base;
      int tx_base;
      int i;

      rst      = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      tl_i     = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst_rx_ready", rx_ready, 1'b1);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_a_valid", tl_o.a_valid, 1'b0);
      check("rst_d_ready", tl_o.d_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_a_address", tl_o.a_address, 32'h0);
      check("rst_a_data", tl_o.a_data, 32'h0);

      $display("txn: write 0x80000000 <= 0xDEADBEEF");
      send_frame(8'h57, 32'h8000_0000, 1'b1, 32'hDEAD_BEEF);
      check("wr_busy", busy, 1'b1);
      check("wr_rx_ready_req", rx_ready, 1'b0);
      serve_tl("wr", 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
      check("wr_latency", tx_valid, 1'b1);
      expect_tx("wr", 40'h4B, 1, -1);

      $display("txn: read 0x80000000 with a_ready stall and tx stall");
      send_frame(8'h52, 32'h8000_0000, 1'b0, 32'h0);
      serve_tl("rd", 1'b0, 32'h8000_0000, 32'h0, 10, 32'h1234_5678, 1'b0);
      expect_tx("rd", 40'h12_34_56_78_4B, 5, 2);

      $display("txn: read 0x80000008 with d_error");
      send_frame(8'h52, 32'h8000_0008, 1'b0, 32'h0);
      serve_tl("rderr", 1'b0, 32'h8000_0008, 32'h0, 0, 32'hFFFF_FFFF, 1'b1);
      expect_tx("rderr", 40'h45, 1, -1);

      $display("txn: unaligned read 0x80000002");
      a_base = a_seen;
      send_frame(8'h52, 32'h8000_0002, 1'b0, 32'h0);
      expect_tx("unal", 40'h45, 1, -1);
      check("unal_no_a_valid", a_seen - a_base, 0);

      $display("txn: bad opcode 0x00");
      send_byte(8'h00);
      expect_tx("badop", 40'h3F, 1, -1);

      $display("txn: write 0x80000004 <= 0x44332211 after bad opcode");
      send_frame(8'h57, 32'h8000_0004, 1'b1, 32'h4433_2211);
      serve_tl("wr2", 1'b1, 32'h8000_0004, 32'h4433_2211, 1, 32'h0, 1'b0);
      expect_tx("wr2", 40'h4B, 1, -1);

      $display("txn: truncated read frame, expecting timeout");
      a_base  = a_seen;
      tx_base = tx_seen;
      send_byte(8'h52);
      send_byte(8'h00);
      i = 0;
      while (busy && i < 40) begin
         @(negedge clk);
         i++;
      end
      check("tmo_busy", busy, 1'b0);
      check("tmo_cycles", i, 16);
      check("tmo_no_tx", tx_seen - tx_base, 0);
      check("tmo_no_a_valid", a_seen - a_base, 0);

      $display("txn: read 0x80000100 after timeout");
      send_frame(8'h52, 32'h8000_0100, 1'b0, 32'h0);
      serve_tl("rd2", 1'b0, 32'h8000_0100, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
      expect_tx("rd2", 40'hCA_FE_F0_0D_4B, 5, -1);

      $display("txn: read 0x80000010 aborted by reset");
      send_frame(8'h52, 32'h8000_0010, 1'b0, 32'h0);
      check("rstmid_a_valid", tl_o.a_valid, 1'b1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rstmid_a_drop", tl_o.a_valid, 1'b0);
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_addr", tl_o.a_address, 32'h0);
      check("rstmid_d_ready", tl_o.d_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      tx_base = tx_seen;
      tl_i.d_valid = 1'b1;
      tl_i.d_data  = 32'h5555_AAAA;
      @(negedge clk);
      check("stray_d_ready", tl_o.d_ready, 1'b1);
      tl_i.d_valid = 1'b0;
      tl_i.d_data  = '0;
      repeat (2) @(negedge clk);
      check("stray_busy", busy, 1'b0);
      check("stray_no_tx", tx_seen - tx_base, 0);

      $display("txn: write 0x80000020 <= 0x01020304 after reset");
      send_frame(8'h57, 32'h8000_0020, 1'b1, 32'h0102_0304);
      serve_tl("wr3", 1'b1, 32'h8000_0020, 32'h0102_0304, 0, 32'h0, 1'b0);
      expect_tx("wr3", 40'h4B, 1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
